// File: rtl/div_iter_if.sv
// Request/response bundle between the execute stage (master) and the iterative divider (slave).
interface div_iter_if #(
  parameter int unsigned N_DATA = 32
);
  logic                  start;
  logic                  signed_div;
  logic [N_DATA-1:0]     opdata1;
  logic [N_DATA-1:0]     opdata2;
  logic                  annul;
  logic [2*N_DATA-1:0]   result;
  logic                  ready;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready
  );
endinterface

// File: rtl/div_iter.sv
// Restoring shift-subtract divider, one quotient bit per cycle; result = {remainder, quotient}.
// Define DIV_ANNUL_EN to let bus.annul flush an in-flight division.
module div_iter #(
  parameter int unsigned N_DATA = 32
) (
  input logic     i_clk,
  input logic     i_rst_n,
  div_iter_if.slave bus
);

  localparam int unsigned CntW = $clog2(N_DATA) + 1;
  localparam logic [CntW-1:0] CntDone = CntW'(N_DATA);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2*N_DATA:0]     work_q, work_d;
  logic [N_DATA-1:0]     divisor_q, divisor_d;
  logic                  signed_q, signed_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic [2*N_DATA-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  annul;
  logic [N_DATA-1:0]     mag_a, mag_b;
  logic [N_DATA:0]       diff;
  logic [N_DATA-1:0]     quot_raw, rem_raw, quot_fix, rem_fix;

`ifdef DIV_ANNUL_EN
  assign annul = bus.annul;
`else
  logic unused_annul;
  assign unused_annul = bus.annul;
  assign annul        = 1'b0;
`endif

  // Two's complement only applies to negative operands of a signed divide.
  assign mag_a = (bus.signed_div && bus.opdata1[N_DATA-1]) ? -bus.opdata1 : bus.opdata1;
  assign mag_b = (bus.signed_div && bus.opdata2[N_DATA-1]) ? -bus.opdata2 : bus.opdata2;

  assign diff     = {1'b0, work_q[2*N_DATA-1:N_DATA]} - {1'b0, divisor_q};
  assign quot_raw = work_q[N_DATA-1:0];
  assign rem_raw  = work_q[2*N_DATA:N_DATA+1];
  assign quot_fix = (signed_q && (sign_a_q ^ sign_b_q)) ? -quot_raw : quot_raw;
  assign rem_fix  = (signed_q && sign_a_q) ? -rem_raw : rem_raw;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      StFree: begin
        if (bus.start && !annul) begin
          signed_d  = bus.signed_div;
          sign_a_d  = bus.opdata1[N_DATA-1];
          sign_b_d  = bus.opdata2[N_DATA-1];
          divisor_d = mag_b;
          cnt_d     = '0;
          if (mag_b == '0) begin
            state_d = StByZero;
          end else begin
            state_d = StOn;
            work_d  = {{N_DATA{1'b0}}, mag_a, 1'b0};
          end
        end
      end
      StByZero: begin
        if (annul) begin
          state_d  = StFree;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          state_d  = StEnd;
          work_d   = '0;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      StOn: begin
        if (annul) begin
          state_d  = StFree;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CntDone) begin
          // A borrow out of the trial subtraction means this quotient bit is 0.
          if (diff[N_DATA]) begin
            work_d = {work_q[2*N_DATA-1:0], 1'b0};
          end else begin
            work_d = {diff[N_DATA-1:0], work_q[N_DATA-1:0], 1'b1};
          end
          cnt_d = cnt_q + CntW'(1);
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          state_d  = StEnd;
        end
      end
      StEnd: begin
        if (!bus.start) begin
          state_d  = StFree;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = StFree;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;

endmodule
